// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result path: FP16 field widths, special
// encodings and the payload carried from the exponent stage to the pack stage.
package mac_pkg;

    localparam int EXP_W     = 5;
    localparam int MANT_W    = 10;
    localparam int DIFF_W    = 5;
    localparam int FP_W      = 1 + EXP_W + MANT_W;

    // Final exponent is held two bits wider than the field so that both the
    // overflow headroom (+4 adjust, +1 carry) and negative results fit.
    localparam int EXP_EXT_W = EXP_W + 2;

    localparam int FP16_BIAS = 15;
    localparam int EXP_MAX   = (1 << EXP_W) - 1;

    localparam logic [EXP_W-1:0]  EXP_INF    = '1;
    localparam logic [EXP_W-1:0]  EXP_ZERO   = '0;
    localparam logic [MANT_W-1:0] FRAC_ZERO  = '0;
    localparam logic [FP_W-1:0]   FP16_ZERO  = '0;

    // Payload registered by S1 and classified by S2.
    typedef struct packed {
        logic signed [EXP_EXT_W-1:0] e;
        logic [MANT_W-1:0]           mant;
        logic                        sign;
        logic                        zero;
    } s1_payload_t;

    // Assemble an FP16 word from its three fields.
    function automatic logic [FP_W-1:0] pack_fp(
        input logic              sign,
        input logic [EXP_W-1:0]  exp_field,
        input logic [MANT_W-1:0] frac
    );
        return {sign, exp_field, frac};
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with a synchronous clear that overrides increment.
module sat_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Clear wins over increment; increment stops once all ones is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fp16_result_pack.sv
// Final stage of the MAC datapath: forms the result exponent, applies the
// overflow (saturate to infinity) and underflow (flush to signed zero) policy,
// packs an FP16 word and hands it downstream through a two-deep valid/ready
// pipeline. Overflow/underflow deliveries are tallied in debug counters.
module fp16_result_pack
    import mac_pkg::*;
#(
    parameter int EXP_W  = mac_pkg::EXP_W,
    parameter int MANT_W = mac_pkg::MANT_W,
    parameter int DIFF_W = mac_pkg::DIFF_W,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W-1:0]          in_base_exp,
    input  logic [MANT_W:0]           in_mant,
    input  logic [DIFF_W-1:0]         in_exp_diff,
    input  logic                      in_exp_carry,
    input  logic                      in_sign,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     out_fp16,
    output logic                      out_ovf,
    output logic                      out_unf,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          ovf_cnt,
    output logic [CNT_W-1:0]          unf_cnt
);

    localparam logic signed [EXP_EXT_W-1:0] EXP_MAX_E = EXP_EXT_W'(EXP_MAX);
    localparam logic signed [EXP_EXT_W-1:0] EXP_ZERO_E = '0;

    // Held low through reset and for the first cycle after release so the
    // stage only starts accepting once the pipeline is known to be empty.
    logic ready_en_reg;

    logic        s1_valid_reg;
    s1_payload_t s1_data_reg;
    s1_payload_t s1_data_next;

    logic                 s2_valid_reg;
    logic [FP_W-1:0]      s2_fp16_reg;
    logic [FP_W-1:0]      s2_fp16_next;
    logic                 s2_ovf_reg;
    logic                 s2_ovf_next;
    logic                 s2_unf_reg;
    logic                 s2_unf_next;

    logic s2_ready;
    logic s1_ready;
    logic accept;

    // A slot can take new data when it is empty or is emptying this cycle.
    assign s2_ready = ~s2_valid_reg | out_ready;
    assign s1_ready = ~s1_valid_reg | s2_ready;
    assign in_ready = ready_en_reg & s1_ready;
    assign accept   = in_valid & in_ready;

    // Exponent formation: base + sign-extended adjust + rounding carry.
    always_comb begin
        s1_data_next      = '0;
        s1_data_next.e    = EXP_EXT_W'(in_base_exp)
                          + EXP_EXT_W'($signed(in_exp_diff))
                          + EXP_EXT_W'(in_exp_carry);
        s1_data_next.mant = in_mant[MANT_W-1:0];
        s1_data_next.sign = in_sign;
        s1_data_next.zero = ~in_mant[MANT_W];
    end

    // Classification in priority order: zero, overflow, underflow, normal.
    always_comb begin
        s2_fp16_next = FP16_ZERO;
        s2_ovf_next  = 1'b0;
        s2_unf_next  = 1'b0;
        if (!s1_data_reg.zero) begin
            if ($signed(s1_data_reg.e) >= EXP_MAX_E) begin
                s2_fp16_next = pack_fp(s1_data_reg.sign, EXP_INF, FRAC_ZERO);
                s2_ovf_next  = 1'b1;
            end else if ($signed(s1_data_reg.e) <= EXP_ZERO_E) begin
                s2_fp16_next = pack_fp(s1_data_reg.sign, EXP_ZERO, FRAC_ZERO);
                s2_unf_next  = 1'b1;
            end else begin
                s2_fp16_next = pack_fp(s1_data_reg.sign,
                                       s1_data_reg.e[EXP_W-1:0],
                                       s1_data_reg.mant);
            end
        end
    end

    // Input-ready enable rises one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // S1: capture a new input whenever the slot is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
        end else if (s1_ready) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_data_reg <= s1_data_next;
            end
        end
    end

    // S2: take the classified S1 result; outputs hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_fp16_reg  <= '0;
            s2_ovf_reg   <= 1'b0;
            s2_unf_reg   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
            s2_fp16_reg  <= s1_valid_reg ? s2_fp16_next : FP16_ZERO;
            s2_ovf_reg   <= s1_valid_reg & s2_ovf_next;
            s2_unf_reg   <= s1_valid_reg & s2_unf_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_fp16  = s2_fp16_reg;
    assign out_ovf   = s2_ovf_reg;
    assign out_unf   = s2_unf_reg;

    // Event counters: index 0 tracks overflow, index 1 underflow.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = s2_valid_reg & out_ready & s2_ovf_reg;
    assign cnt_inc[1] = s2_valid_reg & out_ready & s2_unf_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_event_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (cnt_inc[gi]),
                .clr   (cnt_clr),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign ovf_cnt = cnt_val[0];
    assign unf_cnt = cnt_val[1];

endmodule

// File: tb/tb_fp16_result_pack.sv
// Bench for fp16_result_pack: directed cases from the feature list plus a
// randomized stream, all checked against an arithmetic reference model.
module tb_fp16_result_pack;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       in_base_exp = '0;
    logic [10:0]      in_mant = '0;
    logic [4:0]       in_exp_diff = '0;
    logic             in_exp_carry = 1'b0;
    logic             in_sign = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [15:0]      out_fp16;
    logic             out_ovf;
    logic             out_unf;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] unf_cnt;

    fp16_result_pack #(
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_base_exp  (in_base_exp),
        .in_mant      (in_mant),
        .in_exp_diff  (in_exp_diff),
        .in_exp_carry (in_exp_carry),
        .in_sign      (in_sign),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fp16     (out_fp16),
        .out_ovf      (out_ovf),
        .out_unf      (out_unf),
        .cnt_clr      (cnt_clr),
        .ovf_cnt      (ovf_cnt),
        .unf_cnt      (unf_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass  = 0;
    int n_total = 0;
    int n_out   = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [17:0] res;      // {ovf, unf, fp16}
        int          cyc;
        logic        has_gold;
        logic [17:0] gold;
    } exp_t;

    exp_t exp_q[$];

    logic        lat_en = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        gold_valid = 1'b0;
    logic [17:0] gold_val = '0;
    int          m_ovf = 0;
    int          m_unf = 0;
    logic        held_v = 1'b0;
    logic [17:0] held_val = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: exponent as a plain integer, then classify.
    function automatic logic [17:0] ref_result(input logic [4:0] base, input logic [10:0] mant,
                                               input logic [4:0] diff, input logic carry,
                                               input logic sign);
        int e;
        e = int'(base) + int'($signed(diff)) + int'(carry);
        if (!mant[10]) return 18'd0;
        if (e >= 31) return {2'b10, sign, 5'd31, 10'd0};
        if (e <= 0) return {2'b01, sign, 15'd0};
        return {2'b00, sign, e[4:0], mant[9:0]};
    endfunction

    // Monitor: scoreboard, hold-stability and counter model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ovf  = 0;
            m_unf  = 0;
            held_v = 1'b0;
        end else begin
            logic xo;
            logic xu;
            exp_t e;
            xo = 1'b0;
            xu = 1'b0;
            check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
            check("unf_cnt", 32'(unf_cnt), 32'(m_unf));
            if (held_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({out_ovf, out_unf, out_fp16}), 32'(held_val));
            end
            held_v   = out_valid && !out_ready;
            held_val = {out_ovf, out_unf, out_fp16};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    $display("out %0d: fp16=%04h ovf=%0d unf=%0d", n_out, out_fp16, out_ovf, out_unf);
                    check("result", 32'({out_ovf, out_unf, out_fp16}), 32'(e.res));
                    if (e.has_gold) check("golden", 32'({out_ovf, out_unf, out_fp16}), 32'(e.gold));
                    if (lat_en) check("latency", 32'(cyc - e.cyc), 32'd2);
                    xo = e.res[17];
                    xu = e.res[16];
                end
            end
            if (cnt_clr) begin
                m_ovf = 0;
                m_unf = 0;
            end else begin
                if (xo && m_ovf < CNT_MAX) m_ovf++;
                if (xu && m_unf < CNT_MAX) m_unf++;
            end
            if (in_valid && in_ready) begin
                e.res      = ref_result(in_base_exp, in_mant, in_exp_diff, in_exp_carry, in_sign);
                e.cyc      = cyc;
                e.has_gold = gold_valid;
                e.gold     = gold_val;
                exp_q.push_back(e);
                acc_cnt++;
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [4:0] b, input logic [10:0] m, input logic [4:0] d,
                        input logic c, input logic s, input logic gv, input logic [17:0] g);
        logic acc;
        acc          = 1'b0;
        in_base_exp  = b;
        in_mant      = m;
        in_exp_diff  = d;
        in_exp_carry = c;
        in_sign      = s;
        gold_valid   = gv;
        gold_val     = g;
        in_valid     = 1'b1;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b0;
        gold_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic rnd_send();
        int dv;
        logic [10:0] m;
        dv = int'($urandom_range(0, 14)) - 10;
        m  = ($urandom_range(0, 9) == 0) ? 11'd0 : {1'b1, 10'($urandom)};
        send(5'($urandom), m, dv[4:0], 1'($urandom), 1'($urandom), 1'b0, 18'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        idle(1);
    endtask

    initial begin
        int a0;
        // Reset state
        idle(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_fp16", 32'(out_fp16), 32'd0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 32'(in_ready), 32'd0);
        idle(1);
        check("rel_in_ready_high", 32'(in_ready), 32'd1);

        // Nominal, carry and negative adjust, back-to-back with latency check
        lat_en = 1'b1;
        send(5'd15, 11'h400, 5'h00, 1'b0, 1'b0, 1'b1, {2'b00, 16'h3C00});
        send(5'd15, 11'h400, 5'h00, 1'b1, 1'b0, 1'b1, {2'b00, 16'h4000});
        send(5'd15, 11'h5FF, 5'h1D, 1'b0, 1'b1, 1'b1, {2'b00, 16'hB1FF});
        drain();

        // Overflow / underflow and exponent boundaries
        send(5'd30, 11'h400, 5'h04, 1'b0, 1'b0, 1'b1, {2'b10, 16'h7C00});
        drain();
        check("ovf_cnt_one", 32'(ovf_cnt), 32'd1);
        send(5'd2, 11'h400, 5'h1B, 1'b0, 1'b1, 1'b1, {2'b01, 16'h8000});
        drain();
        check("unf_cnt_one", 32'(unf_cnt), 32'd1);
        send(5'd5, 11'h400, 5'h1B, 1'b0, 1'b0, 1'b1, {2'b01, 16'h0000});
        send(5'd26, 11'h400, 5'h04, 1'b0, 1'b0, 1'b1, {2'b00, 16'h7800});
        send(5'd31, 11'h400, 5'h00, 1'b0, 1'b0, 1'b1, {2'b10, 16'h7C00});
        send(5'd1, 11'h4AB, 5'h00, 1'b0, 1'b0, 1'b1, {2'b00, 16'h04AB});
        send(5'd20, 11'h000, 5'h00, 1'b0, 1'b1, 1'b1, {2'b00, 16'h0000});
        drain();
        lat_en = 1'b0;

        // Backpressure: downstream stalled for 4 cycles while 5 inputs queue
        out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 5; i++) rnd_send();
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                check("bp_accepts", 32'(acc_cnt - a0), 32'd2);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_all_accepted", 32'(acc_cnt - a0), 32'd5);

        // Randomized stream with random gaps and random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rnd_send();
            idle($urandom_range(0, 2));
        end
        rand_rdy = 1'b0;
        idle(1);
        out_ready = 1'b1;
        drain();

        // Counter saturation
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            send(5'd31, 11'h400, 5'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'b0, 18'd0);
        end
        drain();
        check("ovf_cnt_sat", 32'(ovf_cnt), 32'(CNT_MAX));

        // Clear coinciding with an overflow delivery
        out_ready = 1'b0;
        send(5'd31, 11'h400, 5'h02, 1'b0, 1'b0, 1'b0, 18'd0);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        check("clr_pending_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);
        check("clr_unf_cnt", 32'(unf_cnt), 32'd0);
        drain();

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(5'd15, 11'h400, 5'h00, 1'b0, 1'b0, 1'b0, 18'd0);
        send(5'd16, 11'h400, 5'h00, 1'b0, 1'b1, 1'b0, 18'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_out_fp16", 32'(out_fp16), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(5);
        check("post_rst_idle", 32'(out_valid), 32'd0);
        send(5'd15, 11'h400, 5'h00, 1'b0, 1'b0, 1'b1, {2'b00, 16'h3C00});
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
